// File: rtl/ladybird_bus_arbiter.sv
// rtl/ladybird_bus_arbiter.sv - D_BUS/I_BUS arbiter onto one downstream port with in-order response routing.
// Define LADYBIRD_ARB_DBUS_PRIORITY_EN for fixed D_BUS priority instead of round-robin.
module ladybird_bus_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [XLEN-1:0]     d_req_addr,
  input  logic [XLEN-1:0]     d_req_wdata,
  input  logic [XLEN/8-1:0]   d_req_wstrb,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [XLEN-1:0]     i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  input  logic [XLEN/8-1:0]   i_req_wstrb,
  output logic                d_resp_valid,
  output logic [XLEN-1:0]     d_resp_data,
  output logic                i_resp_valid,
  output logic [XLEN-1:0]     i_resp_data,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [XLEN-1:0]     m_req_addr,
  output logic [XLEN-1:0]     m_req_wdata,
  output logic [XLEN/8-1:0]   m_req_wstrb,
  input  logic                m_resp_valid,
  input  logic [XLEN-1:0]     m_resp_data,
  output logic                err
);

  localparam int   PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int   CW   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic ID_D = 1'b0;
  localparam logic ID_I = 1'b1;

  logic [MAX_OUTSTANDING-1:0] r_fifo;
  logic [PW-1:0]              r_wr_ptr;
  logic [PW-1:0]              r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_lock;
  logic                       r_lock_id;
`ifndef LADYBIRD_ARB_DBUS_PRIORITY_EN
  logic                       r_last_grant;
`endif
  logic                       r_d_resp_valid;
  logic                       r_i_resp_valid;
  logic [XLEN-1:0]            r_d_resp_data;
  logic [XLEN-1:0]            r_i_resp_data;
  logic                       r_err;

  logic w_grant;
  logic w_gnt_valid;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_head;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CW'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  // A stalled request keeps its grant so the downstream payload stays stable.
  always_comb begin
    w_grant = ID_D;
    if (r_lock) begin
      w_grant = r_lock_id;
    end else if (d_req_valid && !i_req_valid) begin
      w_grant = ID_D;
    end else if (i_req_valid && !d_req_valid) begin
      w_grant = ID_I;
    end else if (d_req_valid && i_req_valid) begin
`ifdef LADYBIRD_ARB_DBUS_PRIORITY_EN
      w_grant = ID_D;
`else
      w_grant = (r_last_grant == ID_D) ? ID_I : ID_D;
`endif
    end
  end

  assign w_gnt_valid = (w_grant == ID_I) ? i_req_valid : d_req_valid;
  assign m_req_valid = w_gnt_valid && !w_full;
  assign m_req_addr  = !w_gnt_valid ? '0 : (w_grant == ID_I) ? i_req_addr  : d_req_addr;
  assign m_req_wdata = !w_gnt_valid ? '0 : (w_grant == ID_I) ? i_req_wdata : d_req_wdata;
  assign m_req_wstrb = !w_gnt_valid ? '0 : (w_grant == ID_I) ? i_req_wstrb : d_req_wstrb;
  assign d_req_ready = (w_grant == ID_D) && w_gnt_valid && m_req_ready && !w_full;
  assign i_req_ready = (w_grant == ID_I) && w_gnt_valid && m_req_ready && !w_full;

  assign w_push = m_req_valid && m_req_ready;
  assign w_pop  = m_resp_valid && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_lock         <= 1'b0;
      r_lock_id      <= ID_D;
`ifndef LADYBIRD_ARB_DBUS_PRIORITY_EN
      r_last_grant   <= ID_I;
`endif
      r_d_resp_valid <= 1'b0;
      r_i_resp_valid <= 1'b0;
      r_d_resp_data  <= '0;
      r_i_resp_data  <= '0;
      r_err          <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_grant;
        r_wr_ptr         <= f_next(r_wr_ptr);
`ifndef LADYBIRD_ARB_DBUS_PRIORITY_EN
        r_last_grant     <= w_grant;
`endif
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (m_req_valid && !m_req_ready) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_grant;
      end else if (w_push) begin
        r_lock    <= 1'b0;
      end

      r_d_resp_valid <= w_pop && (w_head == ID_D);
      r_i_resp_valid <= w_pop && (w_head == ID_I);
      if (w_pop && (w_head == ID_D)) begin
        r_d_resp_data <= m_resp_data;
      end
      if (w_pop && (w_head == ID_I)) begin
        r_i_resp_data <= m_resp_data;
      end

      // A response with nothing outstanding is dropped and flagged until reset.
      if (m_resp_valid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign d_resp_valid = r_d_resp_valid;
  assign d_resp_data  = r_d_resp_data;
  assign i_resp_valid = r_i_resp_valid;
  assign i_resp_data  = r_i_resp_data;
  assign err          = r_err;

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// tb/tb_ladybird_bus_arbiter.sv - self-checking bench for ladybird_bus_arbiter (round-robin build).
module tb_ladybird_bus_arbiter;

  localparam bit ID_D = 1'b0;
  localparam bit ID_I = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_req_valid, d_req_ready, i_req_valid, i_req_ready;
  logic [31:0] d_req_addr, d_req_wdata, i_req_addr, i_req_wdata;
  logic [3:0]  d_req_wstrb, i_req_wstrb, m_req_wstrb;
  logic        d_resp_valid, i_resp_valid, m_req_valid, m_req_ready, m_resp_valid, err;
  logic [31:0] d_resp_data, i_resp_data, m_req_addr, m_req_wdata, m_resp_data;

  always #5 clk = ~clk;

  ladybird_bus_arbiter #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data), .err(err)
  );

  typedef struct {
    bit dv; bit iv; bit mr; bit rv;
    logic [31:0] da; logic [31:0] ia; logic [31:0] dd; logic [31:0] idd; logic [31:0] rd;
    bit emv; logic [31:0] ema; logic [31:0] emw; logic [3:0] ews; bit edr; bit eir;
  } vec_t;

  typedef struct { bit id; logic [31:0] data; } resp_t;

  int    total = 0;
  int    bad   = 0;
  bit    id_q[$];
  resp_t sb[$];
  bit    exp_err = 1'b0;
  vec_t  tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit dv, input bit iv, input bit mr, input bit rv,
                       input logic [31:0] da, input logic [31:0] ia,
                       input logic [31:0] dd, input logic [31:0] idd, input logic [31:0] rd);
    d_req_valid = dv; i_req_valid = iv; m_req_ready = mr; m_resp_valid = rv;
    d_req_addr = da; i_req_addr = ia; d_req_wdata = dd; i_req_wdata = idd; m_resp_data = rd;
    d_req_wstrb = 4'hF; i_req_wstrb = 4'h0;
  endtask

  // Model: expected IDs queue up on handshakes, responses pop them and become scoreboard entries.
  task automatic tick(input bit push_en, input bit push_id);
    resp_t e;
    @(posedge clk);
    if (m_resp_valid) begin
      if (id_q.size() > 0) begin
        e.id   = id_q.pop_front();
        e.data = m_resp_data;
        sb.push_back(e);
      end else begin
        exp_err = 1'b1;
      end
    end
    if (push_en) id_q.push_back(push_id);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("d_resp_valid", d_resp_valid, e.id == ID_D);
      chk("i_resp_valid", i_resp_valid, e.id == ID_I);
      if (e.id == ID_D) chk("d_resp_data", d_resp_data, e.data);
      else              chk("i_resp_data", i_resp_data, e.data);
    end else begin
      chk("d_resp_idle", d_resp_valid, 0);
      chk("i_resp_idle", i_resp_valid, 0);
    end
    chk("err", err, exp_err);
  endtask

  task automatic cyc(input string tag, input vec_t v);
    drive(v.dv, v.iv, v.mr, v.rv, v.da, v.ia, v.dd, v.idd, v.rd);
    @(negedge clk);
    chk({tag, ".m_req_valid"}, m_req_valid, v.emv);
    chk({tag, ".m_req_addr"}, m_req_addr, v.ema);
    chk({tag, ".m_req_wdata"}, m_req_wdata, v.emw);
    chk({tag, ".m_req_wstrb"}, m_req_wstrb, v.ews);
    chk({tag, ".d_req_ready"}, d_req_ready, v.edr);
    chk({tag, ".i_req_ready"}, i_req_ready, v.eir);
    tick(v.edr | v.eir, v.eir);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    id_q.delete(); sb.delete(); exp_err = 1'b0;
    @(negedge clk);
    chk("rst.m_req_valid", m_req_valid, 0);
    chk("rst.m_req_addr", m_req_addr, 0);
    chk("rst.d_req_ready", d_req_ready, 0);
    chk("rst.i_req_ready", i_req_ready, 0);
    chk("rst.d_resp_valid", d_resp_valid, 0);
    chk("rst.i_resp_valid", i_resp_valid, 0);
    chk("rst.d_resp_data", d_resp_data, 0);
    chk("rst.i_resp_data", i_resp_data, 0);
    chk("rst.err", err, 0);
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(bit dv, bit iv, bit mr, bit rv, logic [31:0] da, logic [31:0] ia,
                              logic [31:0] dd, logic [31:0] idd, logic [31:0] rd, bit emv,
                              logic [31:0] ema, logic [31:0] emw, logic [3:0] ews, bit edr, bit eir);
    vec_t v;
    v.dv = dv; v.iv = iv; v.mr = mr; v.rv = rv; v.da = da; v.ia = ia; v.dd = dd; v.idd = idd;
    v.rd = rd; v.emv = emv; v.ema = ema; v.emw = emw; v.ews = ews; v.edr = edr; v.eir = eir;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(1, 1, 1, 0, 'h100, 'h200, 'hD0, 'hE0, 0,       1, 'h100, 'hD0, 4'hF, 1, 0);
    tbl[1] = mk(1, 1, 1, 0, 'h100, 'h200, 'hD1, 'hE1, 0,       1, 'h200, 'hE1, 4'h0, 0, 1);
    tbl[2] = mk(1, 1, 1, 0, 'h100, 'h200, 'hD2, 'hE2, 0,       0, 'h100, 'hD2, 4'hF, 0, 0);
    tbl[3] = mk(0, 0, 1, 1, 'h100, 'h200, 'hD3, 'hE3, 'hAAAA,  0, 0, 0, 4'h0, 0, 0);
    tbl[4] = mk(0, 0, 1, 1, 0, 0, 0, 0, 'hBBBB,                0, 0, 0, 4'h0, 0, 0);
    tbl[5] = mk(0, 1, 1, 0, 'h104, 'h204, 'hD5, 'hE5, 0,       1, 'h204, 'hE5, 4'h0, 0, 1);
    tbl[6] = mk(1, 1, 1, 1, 'h108, 'h208, 'hD6, 'hE6, 'h1111,  1, 'h108, 'hD6, 4'hF, 1, 0);
    tbl[7] = mk(1, 0, 1, 1, 'h10C, 'h20C, 'hD7, 'hE7, 'h2222,  1, 'h10C, 'hD7, 4'hF, 1, 0);
    tbl[8] = mk(0, 0, 1, 1, 0, 0, 0, 0, 'h3333,                0, 0, 0, 4'h0, 0, 0);

    do_reset();
    foreach (tbl[i]) cyc($sformatf("tbl%0d", i), tbl[i]);

    // Stalled D request keeps the grant although round-robin would now pick I.
    cyc("lock0", mk(1, 0, 0, 0, 'h300, 'h400, 'h30, 'h40, 0, 1, 'h300, 'h30, 4'hF, 0, 0));
    cyc("lock1", mk(1, 1, 0, 0, 'h300, 'h400, 'h30, 'h40, 0, 1, 'h300, 'h30, 4'hF, 0, 0));
    cyc("lock2", mk(1, 1, 0, 0, 'h300, 'h400, 'h30, 'h40, 0, 1, 'h300, 'h30, 4'hF, 0, 0));
    cyc("lock3", mk(1, 1, 1, 0, 'h300, 'h400, 'h30, 'h40, 0, 1, 'h300, 'h30, 4'hF, 1, 0));
    cyc("lock4", mk(0, 1, 1, 0, 'h300, 'h400, 'h30, 'h40, 0, 1, 'h400, 'h40, 4'h0, 0, 1));
    cyc("lock5", mk(0, 0, 1, 1, 0, 0, 0, 0, 'h5555, 0, 0, 0, 4'h0, 0, 0));
    cyc("lock6", mk(0, 0, 1, 1, 0, 0, 0, 0, 'h6666, 0, 0, 0, 4'h0, 0, 0));

    // Full FIFO: a pop in cycle N frees the slot only for cycle N+1.
    cyc("full0", mk(1, 0, 1, 0, 'h10, 0, 'h1, 0, 0, 1, 'h10, 'h1, 4'hF, 1, 0));
    cyc("full1", mk(1, 0, 1, 0, 'h14, 0, 'h2, 0, 0, 1, 'h14, 'h2, 4'hF, 1, 0));
    cyc("full2", mk(1, 0, 1, 0, 'h18, 0, 'h3, 0, 0, 0, 'h18, 'h3, 4'hF, 0, 0));
    cyc("fullN", mk(1, 0, 1, 1, 'h18, 0, 'h3, 0, 'h77, 0, 'h18, 'h3, 4'hF, 0, 0));
    cyc("fullN1", mk(1, 0, 1, 0, 'h18, 0, 'h3, 0, 0, 1, 'h18, 'h3, 4'hF, 1, 0));
    cyc("full5", mk(0, 0, 1, 1, 0, 0, 0, 0, 'h78, 0, 0, 0, 4'h0, 0, 0));
    cyc("full6", mk(0, 0, 1, 1, 0, 0, 0, 0, 'h79, 0, 0, 0, 4'h0, 0, 0));

    // Simultaneous push/pop at count 1 across 8 pointer wraps.
    cyc("wrap_pre", mk(1, 0, 1, 0, 'h500, 0, 'h50, 0, 0, 1, 'h500, 'h50, 4'hF, 1, 0));
    for (int k = 0; k < 16; k++) begin
      bit ev;
      ev = (k % 2 == 0);
      cyc($sformatf("wrap%0d", k),
          mk(ev, !ev, 1, 1, 'h600 + 4 * k, 'h600 + 4 * k, 'hA0 + k, 'hB0 + k, 'hC000 + k,
             1, 'h600 + 4 * k, ev ? 'hA0 + k : 'hB0 + k, ev ? 4'hF : 4'h0, ev, !ev));
    end
    cyc("wrap_post", mk(0, 0, 1, 1, 0, 0, 0, 0, 'hC0FF, 0, 0, 0, 4'h0, 0, 0));

    // Response with nothing outstanding sets the sticky error.
    cyc("err0", mk(0, 0, 1, 1, 0, 0, 0, 0, 'hDEAD, 0, 0, 0, 4'h0, 0, 0));
    for (int k = 0; k < 3; k++) cyc("err_hold", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    cyc("err_push", mk(1, 0, 1, 0, 'h700, 0, 'h70, 0, 0, 1, 'h700, 'h70, 4'hF, 1, 0));
    do_reset();
    cyc("stale", mk(0, 0, 1, 1, 0, 0, 0, 0, 'hBEEF, 0, 0, 0, 4'h0, 0, 0));
    cyc("stale_hold", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ladybird_bus_arbiter.md
Name: ladybird_bus_arbiter

Overview:
- Shares one downstream memory/peripheral port between the core's data bus (D_BUS) and instruction bus (I_BUS), using the package's core_bus_t encoding.
- Arbitrates requests and tracks up to MAX_OUTSTANDING in-flight requests in an ID FIFO.
- Routes in-order downstream responses back to the requester that issued them.
- Sits between the core and the address decoder that selects the access_t target.

Parameters:
XLEN, 32, address/data width
MAX_OUTSTANDING, 2, ID FIFO depth; power of two, >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
d_req_valid  in  1  D_BUS request valid
d_req_ready  out  1  D_BUS request accepted
d_req_addr  in  XLEN  D_BUS address
d_req_wdata  in  XLEN  D_BUS write data
d_req_wstrb  in  XLEN/8  D_BUS byte strobes; 0 = read
i_req_valid  in  1  I_BUS request valid
i_req_ready  out  1  I_BUS request accepted
i_req_addr  in  XLEN  I_BUS address
i_req_wdata  in  XLEN  I_BUS write data (normally 0)
i_req_wstrb  in  XLEN/8  I_BUS strobes (normally 0)
d_resp_valid  out  1  D_BUS response valid
d_resp_data  out  XLEN  D_BUS response data
i_resp_valid  out  1  I_BUS response valid
i_resp_data  out  XLEN  I_BUS response data
m_req_valid  out  1  downstream request valid
m_req_ready  in  1  downstream accepts request
m_req_addr  out  XLEN  downstream address
m_req_wdata  out  XLEN  downstream write data
m_req_wstrb  out  XLEN/8  downstream strobes
m_resp_valid  in  1  downstream response; in request order; one per request (reads and writes)
m_resp_data  in  XLEN  downstream response data
err  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - FIFO empty; lock cleared; last_grant = I_BUS, so D_BUS wins the first contention.
  - d_resp_valid, i_resp_valid, d_resp_data, i_resp_data and err are 0.
  - Combinational outputs (m_req_*, *_req_ready) are 0 while the FIFO is empty and no request is valid.
- Grant selection (combinational):
  - If locked: grant = lock_id.
  - Else, if only one requester is valid: grant it.
  - Else, if both are valid: grant the one != last_grant (round-robin).
- Request forwarding:
  - m_req_valid = granted requester's valid && !full, where full means FIFO count == MAX_OUTSTANDING.
  - m_req_addr, m_req_wdata and m_req_wstrb are muxed from the granted requester.
  - granted *_req_ready = m_req_ready && !full; the non-granted ready is 0.
- Lock:
  - If m_req_valid && !m_req_ready, register lock = 1 and lock_id = grant.
  - The grant must not switch until the handshake completes (payload stable downstream).
  - Lock clears on the handshake.
- On handshake (m_req_valid && m_req_ready): push the grant ID into the FIFO; last_grant <= grant.
- Response path:
  - On m_resp_valid with the FIFO non-empty: pop the head.
  - Next cycle, assert <head>_resp_valid for exactly 1 cycle with <head>_resp_data = m_resp_data. Latency is 1 cycle.
  - The other requester's resp_valid stays 0. Response data holds its last value while valid is low.
- Full FIFO:
  - No push while full, even if a pop occurs in the same cycle; the push proceeds the following cycle.
  - Push and pop in the same cycle when not full: count is unchanged.
- m_resp_valid with the FIFO empty: response dropped, no resp_valid, err <= 1. err stays set until rst.
- A requester deasserting valid before ready is a protocol violation. The lock is still honoured; behaviour is otherwise undefined.
- Reset mid-operation: outstanding IDs are discarded. Downstream must be reset in the same cycle; stale responses afterwards set err.
- The FIFO pointers wrap modulo MAX_OUTSTANDING. The count is $clog2(MAX_OUTSTANDING)+1 bits wide.

Optional Feature:
- Macro: LADYBIRD_ARB_DBUS_PRIORITY_EN
- Defined: fixed priority; D_BUS always wins contention when not locked. last_grant is unused; the lock still applies.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then d and i both valid, m_req_ready=1: cycle 0 grants D_BUS (addr 0x100); cycle 1 grants I_BUS (addr 0x200); FIFO holds D,I; m_resp 0xAAAA then 0xBBBB -> d_resp_data=0xAAAA one cycle later, then i_resp_data=0xBBBB.
- D valid, m_req_ready=0 for 3 cycles while I becomes valid: m_req_addr stays D's address; i_req_ready=0; D handshakes on cycle 4, then I is granted.
- MAX_OUTSTANDING=2, 2 requests accepted with no responses: third request sees ready=0. A response pop in cycle N -> third request accepted in N+1, not N.
- Push and pop in the same cycle with count=1: count stays 1; response routed to the head ID; ordering of IDs preserved over 8 wraps.
- m_resp_valid=1 with FIFO empty: no resp_valid on either bus; err=1 and stays 1 until rst. rst asserted for one cycle clears err and all outputs to 0.
- With LADYBIRD_ARB_DBUS_PRIORITY_EN and both valid continuously: D granted every cycle; I is never granted until D deasserts valid.
